// File: rtl/ip_result_multi_store.sv
// Result write-back stage: captures a multi-field IP result and stores each
// non-empty field to consecutive byte-packed addresses, with a one-deep
// pending slot so a second result can arrive during an active write-back.
module ip_result_multi_store #(
  parameter int NUM_FIELDS = 4,
  parameter int FIELD_W    = 64,
  parameter int ADDR_W     = 32,
  parameter int SIZE_W     = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ip_done,
  input  logic [NUM_FIELDS*FIELD_W-1:0] fields_data,
  input  logic [NUM_FIELDS*SIZE_W-1:0]  field_sizes,
  input  logic [ADDR_W-1:0]             base_addr,
  output logic                          ip_ready,
  output logic                          mem_start,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [FIELD_W-1:0]            mem_data,
  output logic [SIZE_W-1:0]             mem_size,
  input  logic                          mem_done,
  output logic                          done_port,
  output logic                          overflow
);

  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STORE,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  // Active record being written back and the pending record behind it.
  logic [NUM_FIELDS*FIELD_W-1:0] act_data, pend_data;
  logic [NUM_FIELDS*SIZE_W-1:0]  act_sizes, pend_sizes;
  logic [ADDR_W-1:0]             act_base, pend_base;
  logic                          pend_valid;

  // Walk position inside the active record.
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [ADDR_W-1:0] off, off_nxt;

  logic [SIZE_W-1:0]  cur_size;
  logic [FIELD_W-1:0] cur_field;

  logic load_act_in, load_act_pend, load_pend, clr_pend;

  // Keep only the low s bits of a field; sizes above FIELD_W keep everything.
  function automatic logic [FIELD_W-1:0] field_mask(input logic [SIZE_W-1:0] s);
    logic [FIELD_W-1:0] m;
    m = '0;
    for (int b = 0; b < FIELD_W; b++) begin
      if (b < int'(s)) m[b] = 1'b1;
    end
    return m;
  endfunction

  // Bytes occupied by an s-bit field: ceil(s/8).
  function automatic logic [ADDR_W-1:0] bytes_of(input logic [SIZE_W-1:0] s);
    return ADDR_W'((int'(s) + 7) / 8);
  endfunction

  // Select the size and data of the field currently addressed by idx.
  always_comb begin
    cur_size  = '0;
    cur_field = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_size  = act_sizes[i*SIZE_W +: SIZE_W];
        cur_field = act_data[i*FIELD_W +: FIELD_W];
      end
    end
  end

  // Store request is decoded purely from registered state, so it holds steady while waiting.
  always_comb begin
    mem_start = (state == S_STORE) && (cur_size != '0);
    mem_addr  = mem_start ? (act_base + off) : '0;
    mem_data  = mem_start ? (cur_field & field_mask(cur_size)) : '0;
    mem_size  = mem_start ? cur_size : '0;
    done_port = (state == S_FINISH);
    ip_ready  = !pend_valid;
  end

  // Next-state, walk position and slot-load decisions.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    off_nxt       = off;
    load_act_in   = 1'b0;
    load_act_pend = 1'b0;
    load_pend     = 1'b0;
    clr_pend      = 1'b0;
    case (state)
      S_IDLE: begin
        if (ip_done) begin
          load_act_in = 1'b1;
          state_nxt   = S_STORE;
          idx_nxt     = '0;
          off_nxt     = '0;
        end
      end
      S_STORE: begin
        if (ip_done && !pend_valid) load_pend = 1'b1;
        if ((cur_size == '0) || mem_done) begin
          if (cur_size != '0) off_nxt = off + bytes_of(cur_size);
          if (idx == LAST_IDX) begin
            state_nxt = S_FINISH;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      S_FINISH: begin
        // A result already pending, or one arriving right now, starts the next walk.
        if (pend_valid) begin
          load_act_pend = 1'b1;
          clr_pend      = 1'b1;
          state_nxt     = S_STORE;
          idx_nxt       = '0;
          off_nxt       = '0;
        end else if (ip_done) begin
          load_act_in = 1'b1;
          state_nxt   = S_STORE;
          idx_nxt     = '0;
          off_nxt     = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Control registers: walk position, pending flag, sticky overflow.
  always_ff @(posedge clock) begin
    if (!reset) begin
      idx        <= '0;
      off        <= '0;
      pend_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      idx <= idx_nxt;
      off <= off_nxt;
      if (load_pend)     pend_valid <= 1'b1;
      else if (clr_pend) pend_valid <= 1'b0;
      if (ip_done && pend_valid) overflow <= 1'b1;
    end
  end

  // Record payload registers; validity is tracked by the control registers.
  always_ff @(posedge clock) begin
    if (load_act_in) begin
      act_data  <= fields_data;
      act_sizes <= field_sizes;
      act_base  <= base_addr;
    end else if (load_act_pend) begin
      act_data  <= pend_data;
      act_sizes <= pend_sizes;
      act_base  <= pend_base;
    end
    if (load_pend) begin
      pend_data  <= fields_data;
      pend_sizes <= field_sizes;
      pend_base  <= base_addr;
    end
  end

endmodule
